// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (x, y) over GF(2^255-19) plus Ed25519 encoding; Z^-1 via Fermat
// on one bit-serial interleaved multiplier (256 cycles/multiply, 508 multiplies per conversion).
module proj_to_affine (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [254:0] i_x,
    input  logic [254:0] i_y,
    input  logic [254:0] i_z,
    output logic [254:0] o_x,
    output logic [254:0] o_y,
    output logic [255:0] o_enc,
    output logic         o_z_zero,
    output logic         o_busy,
    output logic         o_finished
);

    localparam logic [255:0] P      = {1'b0, 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed};
    // Low five bits of p-2; every exponent bit from 5 upward is a one.
    localparam logic [7:0]   EXP_LO = 8'b0000_1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV_SQR,
        S_INV_MUL,
        S_MUL_X,
        S_MUL_Y,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [254:0] r_x, r_y, r_z, r_r, r_xc, r_yc;
    logic [7:0]   r_e;
    logic         r_zz;
    logic [254:0] r_ox, r_oy;
    logic [255:0] r_enc;
    logic         r_ozz, r_busy, r_fin;

    logic [254:0] r_acc;
    logic [7:0]   r_k;
    logic         r_mload;

    logic         w_mul_act, w_mul_done, w_bit, w_ebit;
    logic [254:0] w_op_a, w_op_b, w_dbl_red, w_acc_nxt;
    logic [255:0] w_dbl, w_sum;

    assign w_mul_act  = (r_state == S_INV_SQR) || (r_state == S_INV_MUL) ||
                        (r_state == S_MUL_X)   || (r_state == S_MUL_Y);
    assign w_mul_done = w_mul_act && !r_mload && (r_k == 8'd0);
    assign w_ebit     = (r_e >= 8'd5) || EXP_LO[r_e[2:0]];

    always_comb begin
        w_op_a = r_r;
        w_op_b = r_r;
        if (r_state == S_MUL_X) w_op_a = r_x;
        if (r_state == S_MUL_Y) w_op_a = r_y;
        if (r_state == S_INV_MUL) w_op_b = r_z;
    end

    // One MSB-first step: double, then conditionally add; each stays below p with one compare.
    always_comb begin
        w_bit     = w_op_b[r_k];
        w_dbl     = {r_acc, 1'b0};
        w_dbl_red = (w_dbl >= P) ? 255'(w_dbl - P) : 255'(w_dbl);
        w_sum     = {1'b0, w_dbl_red} + {1'b0, w_op_a};
        w_acc_nxt = w_dbl_red;
        if (w_bit) w_acc_nxt = (w_sum >= P) ? 255'(w_sum - P) : 255'(w_sum);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_k     <= 8'd254;
            r_mload <= 1'b1;
        end else if (!w_mul_act) begin
            r_acc   <= '0;
            r_k     <= 8'd254;
            r_mload <= 1'b1;
        end else if (r_mload) begin
            r_acc   <= '0;
            r_k     <= 8'd254;
            r_mload <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            if (r_k == 8'd0) r_mload <= 1'b1;
            else             r_k     <= r_k - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_r     <= '0;
            r_xc    <= '0;
            r_yc    <= '0;
            r_e     <= '0;
            r_zz    <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_enc   <= '0;
            r_ozz   <= 1'b0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_busy still set here means this is the o_finished cycle: no acceptance yet.
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (i_start) begin
                        r_x     <= i_x;
                        r_y     <= i_y;
                        r_z     <= i_z;
                        r_r     <= i_z;
                        r_e     <= 8'd253;
                        r_zz    <= (i_z == '0);
                        r_busy  <= 1'b1;
                        r_state <= S_INV_SQR;
                    end
                end
                S_INV_SQR: begin
                    if (w_mul_done) begin
                        r_r <= w_acc_nxt;
                        if (w_ebit)                r_state <= S_INV_MUL;
                        else if (r_e == 8'd0)      r_state <= S_MUL_X;
                        else                       r_e     <= r_e - 8'd1;
                    end
                end
                S_INV_MUL: begin
                    if (w_mul_done) begin
                        r_r <= w_acc_nxt;
                        if (r_e == 8'd0) begin
                            r_state <= S_MUL_X;
                        end else begin
                            r_e     <= r_e - 8'd1;
                            r_state <= S_INV_SQR;
                        end
                    end
                end
                S_MUL_X: begin
                    if (w_mul_done) begin
                        r_xc    <= w_acc_nxt;
                        r_state <= S_MUL_Y;
                    end
                end
                S_MUL_Y: begin
                    if (w_mul_done) begin
                        r_yc    <= w_acc_nxt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ox    <= r_xc;
                    r_oy    <= r_yc;
                    r_enc   <= {r_xc[0], r_yc};
                    r_ozz   <= r_zz;
                    r_fin   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_x        = r_ox;
    assign o_y        = r_oy;
    assign o_enc      = r_enc;
    assign o_z_zero   = r_ozz;
    assign o_busy     = r_busy;
    assign o_finished = r_fin;

endmodule
